tdm_demux_four: RTL and testbench

- Receive-side counterpart of the team's 4:1 mux, run as a time-division link.
- Takes one serial data line carrying four time slots per frame, marked by a frame-sync flag on slot 0.
- Stages the slots and commits all four channel outputs together once a frame is complete.
- Sits after a TDM source or mux path in lab datapaths and recovers channels i0..i3 as o0..o3.

---
 rtl/tdm_demux_four_pkg.sv | 15 +
 rtl/tdm_slot_counter.sv | 38 +++
 rtl/tdm_demux_four.sv | 187 ++++++++++++++++++
 tb/tb_tdm_demux_four.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_four_pkg.sv
// Shared definitions for the four-channel TDM demultiplexer.
//   NUM_CH  : number of channels (time slots) per frame
//   SLOT_W  : width of the slot index
//   state_t : framing state (HUNT searching for sync, LOCKED tracking slots)
package tdm_demux_four_pkg;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter for the TDM demultiplexer.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset (s -> 0)
//   clear    : synchronous clear to 0 (highest priority)
//   load_one : synchronous load to 1 (slot 0 just consumed)
//   incr     : synchronous increment, wraps 3 -> 0
//   s        : registered slot index expected for the next sample
module tdm_slot_counter
    import tdm_demux_four_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load_one,
    input  logic              incr,
    output logic [SLOT_W-1:0] s
);

    localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};
    localparam logic [SLOT_W-1:0] SLOT_ONE  = {{(SLOT_W-1){1'b0}}, 1'b1};

    // Slot index register; clear beats load beats increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s <= SLOT_ZERO;
        end else if (clear) begin
            s <= SLOT_ZERO;
        end else if (load_one) begin
            s <= SLOT_ONE;
        end else if (incr) begin
            s <= s + SLOT_ONE;
        end else begin
            s <= s;
        end
    end

endmodule

// File: rtl/tdm_demux_four.sv
// Four-channel TDM demultiplexer.
// One serial line carries four slots per frame; slot 0 is flagged by sync.
// Slots 0..2 are staged and all four channel outputs are committed together
// when slot 3 arrives, so the outputs never mix samples of two frames.
// Ports:
//   clk, reset_n       : clock and asynchronous active-low reset
//   d, valid, sync     : TDM sample, sample-present flag, slot-0 marker
//   o0..o3             : recovered channels, held between commits
//   s                  : slot index expected for the next valid sample
//   locked             : framing locked
//   frame_done         : one-cycle pulse, o0..o3 updated this cycle
//   sync_err           : one-cycle pulse, framing violation seen
module tdm_demux_four
    import tdm_demux_four_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  d,
    input  logic              valid,
    input  logic              sync,
    output logic [WIDTH-1:0]  o3,
    output logic [WIDTH-1:0]  o2,
    output logic [WIDTH-1:0]  o1,
    output logic [WIDTH-1:0]  o0,
    output logic [1:0]        s,
    output logic              locked,
    output logic              frame_done,
    output logic              sync_err
);

    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    state_t               state_r;
    state_t               state_nxt_s;
    logic [WIDTH-1:0]     stage0_r;
    logic [WIDTH-1:0]     stage1_r;
    logic [WIDTH-1:0]     stage2_r;
    logic [NUM_CH-2:0]    stage_we_s;
    logic                 clear_s;
    logic                 load_one_s;
    logic                 incr_s;
    logic                 commit_s;
    logic                 err_s;
    logic                 frame_done_r;
    logic                 sync_err_r;
    logic [SLOT_W-1:0]    slot_s;

    tdm_slot_counter u_slot_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear_s),
        .load_one (load_one_s),
        .incr     (incr_s),
        .s        (slot_s)
    );

    // Framing state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, slot-counter controls, stage writes, commit and error.
    always_comb begin
        state_nxt_s = state_r;
        clear_s     = 1'b0;
        load_one_s  = 1'b0;
        incr_s      = 1'b0;
        stage_we_s  = {(NUM_CH-1){1'b0}};
        commit_s    = 1'b0;
        err_s       = 1'b0;
        if (valid) begin
            case (state_r)
                HUNT: begin
                    if (sync) begin
                        load_one_s    = 1'b1;
                        stage_we_s[0] = 1'b1;
                        state_nxt_s   = LOCKED;
                    end else begin
                        // Unframed sample: dropped silently, keep s at 0.
                        clear_s = 1'b1;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // Sync always starts a new frame; mid-frame it also
                        // flags an error and the partial frame is abandoned.
                        load_one_s    = 1'b1;
                        stage_we_s[0] = 1'b1;
                        if (slot_s != 2'd0) begin
                            err_s = 1'b1;
                        end else begin
                            err_s = 1'b0;
                        end
                    end else begin
                        case (slot_s)
                            2'd0: begin
                                // Slot 0 without sync: framing lost.
                                err_s       = 1'b1;
                                clear_s     = 1'b1;
                                state_nxt_s = HUNT;
                            end
                            2'd1: begin
                                stage_we_s[1] = 1'b1;
                                incr_s        = 1'b1;
                            end
                            2'd2: begin
                                stage_we_s[2] = 1'b1;
                                incr_s        = 1'b1;
                            end
                            2'd3: begin
                                commit_s = 1'b1;
                                incr_s   = 1'b1;
                            end
                            default: begin
                                clear_s     = 1'b1;
                                state_nxt_s = HUNT;
                            end
                        endcase
                    end
                end
                default: begin
                    clear_s     = 1'b1;
                    state_nxt_s = HUNT;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Staging registers, committed channel outputs and status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage0_r     <= DATA_ZERO;
            stage1_r     <= DATA_ZERO;
            stage2_r     <= DATA_ZERO;
            o0           <= DATA_ZERO;
            o1           <= DATA_ZERO;
            o2           <= DATA_ZERO;
            o3           <= DATA_ZERO;
            frame_done_r <= 1'b0;
            sync_err_r   <= 1'b0;
        end else begin
            if (stage_we_s[0]) begin
                stage0_r <= d;
            end else begin
                stage0_r <= stage0_r;
            end
            if (stage_we_s[1]) begin
                stage1_r <= d;
            end else begin
                stage1_r <= stage1_r;
            end
            if (stage_we_s[2]) begin
                stage2_r <= d;
            end else begin
                stage2_r <= stage2_r;
            end
            // Slot 3 goes straight to o3 so the frame lands in one edge.
            if (commit_s) begin
                o0 <= stage0_r;
                o1 <= stage1_r;
                o2 <= stage2_r;
                o3 <= d;
            end else begin
                o0 <= o0;
                o1 <= o1;
                o2 <= o2;
                o3 <= o3;
            end
            frame_done_r <= commit_s;
            sync_err_r   <= err_s;
        end
    end

    assign s          = slot_s;
    assign locked     = (state_r == LOCKED);
    assign frame_done = frame_done_r;
    assign sync_err   = sync_err_r;

endmodule

// File: tb/tb_tdm_demux_four.sv
// Self-checking bench for tdm_demux_four (WIDTH=4): directed scenarios
// followed by randomized traffic against a queue-based frame model.
module tb_tdm_demux_four;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [W-1:0] d = '0;
    logic         valid = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] o3, o2, o1, o0;
    logic [1:0]   s;
    logic         locked, frame_done, sync_err;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: frame in progress held as a queue of samples.
    logic [W-1:0] m_out [4];
    logic [W-1:0] m_q [$];
    bit           m_lock;
    bit           m_done;
    bit           m_err;

    tdm_demux_four #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d          (d),
        .valid      (valid),
        .sync       (sync),
        .o3         (o3),
        .o2         (o2),
        .o1         (o1),
        .o0         (o0),
        .s          (s),
        .locked     (locked),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        m_q.delete();
        m_lock = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit sy, input logic [W-1:0] dd);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (v) begin
            if (!m_lock) begin
                if (sy) begin
                    m_q.delete();
                    m_q.push_back(dd);
                    m_lock = 1'b1;
                end
            end else if (sy) begin
                m_err = (m_q.size() != 0);
                m_q.delete();
                m_q.push_back(dd);
            end else if (m_q.size() == 0) begin
                m_err  = 1'b1;
                m_lock = 1'b0;
            end else begin
                m_q.push_back(dd);
                if (m_q.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_out[i] = m_q[i];
                    m_q.delete();
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("o0", o0, m_out[0]);
        chk("o1", o1, m_out[1]);
        chk("o2", o2, m_out[2]);
        chk("o3", o3, m_out[3]);
        chk("s", s, m_q.size());
        chk("locked", locked, m_lock);
        chk("frame_done", frame_done, m_done);
        chk("sync_err", sync_err, m_err);
        chk("done_err_excl", frame_done & sync_err, 0);
    endtask

    // Check the outputs produced by the previous edge, then drive the next sample.
    task automatic step(input bit v, input bit sy, input logic [W-1:0] dd);
        @(negedge clk);
        check_all();
        valid = v;
        sync  = sy;
        d     = dd;
        model_step(v, sy, dd);
    endtask

    // Asynchronous reset applied between edges, held for two cycles.
    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        valid   = 1'b0;
        sync    = 1'b0;
        d       = '0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        chk("reset_o0", o0, 0);
        chk("reset_locked", locked, 0);

        // Clean frame
        step(1, 1, 4'h3);
        step(1, 0, 4'h9);
        step(1, 0, 4'hC);
        step(1, 0, 4'h6);
        step(0, 0, 0);
        chk("clean_o0", o0, 4'h3);
        chk("clean_o1", o1, 4'h9);
        chk("clean_o2", o2, 4'hC);
        chk("clean_o3", o3, 4'h6);
        chk("clean_done", frame_done, 1);
        step(0, 0, 0);
        chk("clean_done_1cyc", frame_done, 0);

        // Gapped frame
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("gap_hold_o0", o0, 4'h3);
        step(1, 0, 4'h4);
        step(1, 0, 4'h8);
        step(0, 0, 0);
        chk("gap_o0", o0, 4'h1);
        chk("gap_o3", o3, 4'h8);

        // Early sync
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        step(1, 1, 4'h5);
        step(1, 0, 4'h6);
        chk("early_err", sync_err, 1);
        chk("early_hold_o0", o0, 4'h1);
        step(1, 0, 4'h7);
        step(1, 0, 4'h8);
        step(0, 0, 0);
        chk("early_o0", o0, 4'h5);
        chk("early_o1", o1, 4'h6);
        chk("early_o2", o2, 4'h7);
        chk("early_o3", o3, 4'h8);

        // Missing sync, then relock
        step(1, 0, 4'h9);
        step(0, 0, 0);
        chk("miss_err", sync_err, 1);
        chk("miss_locked", locked, 0);
        chk("miss_o0", o0, 4'h5);
        step(1, 1, 4'hA);
        step(0, 0, 0);
        chk("relock", locked, 1);
        chk("relock_s", s, 1);

        // Reset mid-frame
        step(1, 0, 4'hB);
        step(1, 0, 4'hB);
        step(1, 0, 4'hB);
        step(1, 1, 4'hF);
        step(1, 0, 4'hE);
        step(1, 0, 4'hD);
        step(1, 0, 4'hC);
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        step(1, 0, 4'h3);
        step(0, 0, 0);
        chk("pre_rst_o0", o0, 4'hF);
        chk("pre_rst_o3", o3, 4'hC);
        do_reset();
        chk("rst_mid_o0", o0, 0);
        chk("rst_mid_o3", o3, 0);
        step(1, 0, 4'h4);
        step(0, 0, 0);
        chk("rst_no_commit", frame_done, 0);
        chk("rst_no_commit_o3", o3, 0);

        // Randomized traffic, mostly well-framed with occasional violations
        for (int n = 0; n < 3000; n++) begin
            bit v;
            bit sy;
            v  = ($urandom_range(0, 3) != 0);
            sy = (m_q.size() == 0) ^ ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step(v, sy, W'($urandom));
            end
        end
        step(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
